// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for a uart_rx core. It arms the core only after the line has
// idled for one bit time, then buffers received bytes in a first-word-fall-through FIFO.
module uart_rx_ctrl #(
    parameter  int DEPTH        = 16,
    parameter  int TIMEOUT_BITS = 32,
    parameter  int MIN_CPB      = 4,
    localparam int AW           = $clog2(DEPTH),
    localparam int LW           = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cfg_en_i,
    input  logic [15:0]   cfg_cpb_i,
    input  logic [LW-1:0] cfg_wm_i,
    input  logic          clr_i,
    input  logic          rx_i,
    output logic          core_rst_no,
    output logic [15:0]   core_cpb_o,
    input  logic          core_dv_i,
    input  logic [7:0]    core_byte_i,
    output logic          rd_valid_o,
    output logic [7:0]    rd_data_o,
    input  logic          rd_ready_i,
    output logic [LW-1:0] level_o,
    output logic          wm_irq_o,
    output logic          overflow_o,
    output logic          timeout_o,
    output logic          active_o
);

    localparam int TW = $clog2(TIMEOUT_BITS + 1);
    localparam logic [15:0]   MIN_CPB_W = 16'(MIN_CPB);
    localparam logic [TW-1:0] TO_W      = TW'(TIMEOUT_BITS);
    localparam logic [LW-1:0] DEPTH_W   = LW'(DEPTH);

    typedef enum logic [1:0] {
        S_OFF = 2'd0,
        S_ARM = 2'd1,
        S_RUN = 2'd2
    } state_t;

    state_t          state_reg;
    logic [15:0]     cpb_reg;
    logic [15:0]     idle_cnt_reg;
    logic            core_rst_n_reg;
    logic            active_reg;
    logic [1:0]      sync_reg;
    logic            rx_sync;
    logic [15:0]     cpb_floor;
    logic [15:0]     cpb_last;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [LW-1:0]   level_reg;
    logic [7:0]      head_reg;
    logic [AW-1:0]   wr_ptr_next;
    logic [AW-1:0]   rd_ptr_next;
    logic [LW-1:0]   level_next;

    logic            rd_valid;
    logic            full;
    logic            push_req;
    logic            pop;
    logic            push;
    logic            drop;

    logic            overflow_reg;
    logic            timeout_reg;
    logic [15:0]     cyc_cnt_reg;
    logic [TW-1:0]   bit_cnt_reg;

    // The pad is asynchronous; two flops, idle-high out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx_i};
        end
    end

    assign rx_sync   = sync_reg[1];
    assign cpb_floor = (cfg_cpb_i < MIN_CPB_W) ? MIN_CPB_W : cfg_cpb_i;
    assign cpb_last  = cpb_reg - 16'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= S_OFF;
            cpb_reg        <= MIN_CPB_W;
            idle_cnt_reg   <= '0;
            core_rst_n_reg <= 1'b0;
            active_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_OFF: begin
                    if (cfg_en_i) begin
                        cpb_reg        <= cpb_floor;
                        idle_cnt_reg   <= '0;
                        core_rst_n_reg <= 1'b1;
                        state_reg      <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (!cfg_en_i) begin
                        core_rst_n_reg <= 1'b0;
                        state_reg      <= S_OFF;
                    end else if (!rx_sync) begin
                        idle_cnt_reg <= '0;
                    end else if (idle_cnt_reg == cpb_last) begin
                        active_reg <= 1'b1;
                        state_reg  <= S_RUN;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + 16'd1;
                    end
                end
                S_RUN: begin
                    if (!cfg_en_i) begin
                        core_rst_n_reg <= 1'b0;
                        active_reg     <= 1'b0;
                        state_reg      <= S_OFF;
                    end
                end
                default: begin
                    core_rst_n_reg <= 1'b0;
                    active_reg     <= 1'b0;
                    state_reg      <= S_OFF;
                end
            endcase
        end
    end

    assign rd_valid = (level_reg != '0);
    assign full     = (level_reg == DEPTH_W);
    assign push_req = core_dv_i && (state_reg == S_RUN);
    assign pop      = rd_valid && rd_ready_i;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push && !clr_i) begin
            mem[wr_ptr_reg] <= core_byte_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            head_reg   <= '0;
        end else if (clr_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            // The registered head bypasses the array when the incoming byte becomes the head.
            if (level_next == '0) begin
                head_reg <= '0;
            end else if (push && ((level_reg == '0) || ((level_reg == LW'(1)) && pop))) begin
                head_reg <= core_byte_i;
            end else begin
                head_reg <= mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_reg <= 1'b0;
            timeout_reg  <= 1'b0;
            cyc_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
        end else begin
            if (clr_i) begin
                overflow_reg <= 1'b0;
            end else if (drop) begin
                overflow_reg <= 1'b1;
            end

            if (clr_i) begin
                timeout_reg <= 1'b0;
            end else if ((state_reg == S_RUN) && rd_valid && (bit_cnt_reg == TO_W)) begin
                timeout_reg <= 1'b1;
            end

            // Idle bit-time measurement restarts on any FIFO activity.
            if (clr_i || push || pop || !rd_valid || (state_reg != S_RUN)) begin
                cyc_cnt_reg <= '0;
                bit_cnt_reg <= '0;
            end else if (bit_cnt_reg != TO_W) begin
                if (cyc_cnt_reg == cpb_last) begin
                    cyc_cnt_reg <= '0;
                    bit_cnt_reg <= bit_cnt_reg + TW'(1);
                end else begin
                    cyc_cnt_reg <= cyc_cnt_reg + 16'd1;
                end
            end
        end
    end

    assign core_rst_no = core_rst_n_reg;
    assign core_cpb_o  = cpb_reg;
    assign rd_valid_o  = rd_valid;
    assign rd_data_o   = head_reg;
    assign level_o     = level_reg;
    assign wm_irq_o    = (cfg_wm_i != '0) && (level_reg >= cfg_wm_i);
    assign overflow_o  = overflow_reg;
    assign timeout_o   = timeout_reg;
    assign active_o    = active_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed stimulus, a queue-based reference model compared
// every cycle, and hand-computed spot checks at the interesting points.
module tb_uart_rx_ctrl;

    localparam int DEPTH        = 16;
    localparam int TIMEOUT_BITS = 32;
    localparam int MIN_CPB      = 4;
    localparam int LW           = $clog2(DEPTH) + 1;
    localparam int S_OFF = 0;
    localparam int S_ARM = 1;
    localparam int S_RUN = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cfg_en_i;
    logic [15:0]   cfg_cpb_i;
    logic [LW-1:0] cfg_wm_i;
    logic          clr_i;
    logic          rx_i;
    logic          core_rst_no;
    logic [15:0]   core_cpb_o;
    logic          core_dv_i;
    logic [7:0]    core_byte_i;
    logic          rd_valid_o;
    logic [7:0]    rd_data_o;
    logic          rd_ready_i;
    logic [LW-1:0] level_o;
    logic          wm_irq_o;
    logic          overflow_o;
    logic          timeout_o;
    logic          active_o;

    always #5 clk_i = ~clk_i;

    uart_rx_ctrl #(
        .DEPTH(DEPTH),
        .TIMEOUT_BITS(TIMEOUT_BITS),
        .MIN_CPB(MIN_CPB)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .cfg_en_i(cfg_en_i),
        .cfg_cpb_i(cfg_cpb_i),
        .cfg_wm_i(cfg_wm_i),
        .clr_i(clr_i),
        .rx_i(rx_i),
        .core_rst_no(core_rst_no),
        .core_cpb_o(core_cpb_o),
        .core_dv_i(core_dv_i),
        .core_byte_i(core_byte_i),
        .rd_valid_o(rd_valid_o),
        .rd_data_o(rd_data_o),
        .rd_ready_i(rd_ready_i),
        .level_o(level_o),
        .wm_irq_o(wm_irq_o),
        .overflow_o(overflow_o),
        .timeout_o(timeout_o),
        .active_o(active_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: state as a plain integer, FIFO as a queue, timeout as a count
    // of quiet cycles compared against TIMEOUT_BITS whole bit times.
    int           m_state = S_OFF;
    int           m_cpb   = MIN_CPB;
    int           m_high  = 0;
    int           m_quiet = 0;
    bit           m_s1    = 1'b1;
    bit           m_s2    = 1'b1;
    bit           m_ovf   = 1'b0;
    bit           m_to    = 1'b0;
    byte unsigned m_q[$];

    always @(posedge clk_i or posedge rst_i) begin : model
        int lvl;
        int st;
        bit sync;
        bit push_req;
        bit pop;
        bit push;
        bit drop;
        if (rst_i) begin
            m_state = S_OFF;
            m_cpb   = MIN_CPB;
            m_high  = 0;
            m_quiet = 0;
            m_s1    = 1'b1;
            m_s2    = 1'b1;
            m_ovf   = 1'b0;
            m_to    = 1'b0;
            m_q.delete();
        end else begin
            lvl  = m_q.size();
            st   = m_state;
            sync = m_s2;
            m_s2 = m_s1;
            m_s1 = rx_i;

            push_req = core_dv_i && (st == S_RUN);
            pop      = (lvl > 0) && rd_ready_i;
            push     = push_req && ((lvl < DEPTH) || pop);
            drop     = push_req && (lvl == DEPTH) && !pop;

            if (clr_i) m_to = 1'b0;
            else if ((st == S_RUN) && (lvl > 0) && (m_quiet == TIMEOUT_BITS * m_cpb)) m_to = 1'b1;

            if (clr_i || push || pop || (lvl == 0) || (st != S_RUN)) m_quiet = 0;
            else if (m_quiet < TIMEOUT_BITS * m_cpb) m_quiet++;

            if (clr_i) begin
                m_q.delete();
                m_ovf = 1'b0;
            end else begin
                if (drop) m_ovf = 1'b1;
                if (pop) void'(m_q.pop_front());
                if (push) m_q.push_back(core_byte_i);
            end

            if (st == S_OFF) begin
                if (cfg_en_i) begin
                    m_cpb   = (int'(cfg_cpb_i) < MIN_CPB) ? MIN_CPB : int'(cfg_cpb_i);
                    m_high  = 0;
                    m_state = S_ARM;
                end
            end else if (!cfg_en_i) begin
                m_state = S_OFF;
            end else if (st == S_ARM) begin
                // RUN once cpb consecutive synchronised high samples were seen.
                if (sync) begin
                    m_high++;
                    if (m_high == m_cpb) m_state = S_RUN;
                end else begin
                    m_high = 0;
                end
            end
        end
    end

    always @(posedge clk_i) begin
        #2;
        check("core_rst_no", 32'(core_rst_no), 32'(m_state != S_OFF));
        check("core_cpb",    32'(core_cpb_o),  m_cpb);
        check("active",      32'(active_o),    32'(m_state == S_RUN));
        check("level",       32'(level_o),     m_q.size());
        check("rd_valid",    32'(rd_valid_o),  32'(m_q.size() > 0));
        check("rd_data",     32'(rd_data_o),   (m_q.size() > 0) ? int'(m_q[0]) : 0);
        check("overflow",    32'(overflow_o),  32'(m_ovf));
        check("timeout",     32'(timeout_o),   32'(m_to));
        check("wm_irq",      32'(wm_irq_o),
              32'((cfg_wm_i != '0) && (m_q.size() >= int'(cfg_wm_i))));
    end

    task automatic step(int n = 1);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic push_byte(logic [7:0] b);
        core_dv_i   = 1'b1;
        core_byte_i = b;
        step();
        core_dv_i   = 1'b0;
        $display("[TB] push 0x%02h -> level %0d", b, level_o);
    endtask

    initial begin
        logic [7:0] last;
        rst_i = 1'b1; cfg_en_i = 1'b0; cfg_cpb_i = 16'd16; cfg_wm_i = '0;
        clr_i = 1'b0; rx_i = 1'b1; core_dv_i = 1'b0; core_byte_i = 8'h00; rd_ready_i = 1'b0;
        step(3);
        check("rst core_rst_no", 32'(core_rst_no), 0);
        check("rst core_cpb",    32'(core_cpb_o), 4);
        check("rst level",       32'(level_o), 0);
        check("rst rd_data",     32'(rd_data_o), 0);
        check("rst active",      32'(active_o), 0);
        rst_i = 1'b0;
        step(2);

        // Arm with cpb=16 and an idle line.
        cfg_en_i = 1'b1;
        step();
        $display("[TB] enable cpb=16: core_rst_no=%0d core_cpb=%0d", core_rst_no, core_cpb_o);
        check("arm core_rst_no", 32'(core_rst_no), 1);
        check("arm core_cpb",    32'(core_cpb_o), 16);
        step(15);
        check("arm cycle15 active", 32'(active_o), 0);
        step();
        check("arm cycle16 active", 32'(active_o), 1);

        // Line low while arming restarts the idle qualification.
        cfg_en_i = 1'b0;
        step();
        check("disable active", 32'(active_o), 0);
        check("disable core_rst_no", 32'(core_rst_no), 0);
        rx_i = 1'b0; cfg_en_i = 1'b1;
        step(10);
        rx_i = 1'b1;
        step(17);
        check("rxlow not yet run", 32'(active_o), 0);
        step();
        check("rxlow run", 32'(active_o), 1);
        $display("[TB] rx low 10 then idle: active=%0d", active_o);

        // cpb floor and hold while running.
        cfg_en_i = 1'b0;
        step();
        cfg_cpb_i = 16'd1; cfg_en_i = 1'b1;
        step();
        check("cpb floor", 32'(core_cpb_o), 4);
        step(3);
        check("cpb4 not yet run", 32'(active_o), 0);
        step();
        check("cpb4 run", 32'(active_o), 1);
        cfg_cpb_i = 16'd100;
        step(3);
        check("cpb held in run", 32'(core_cpb_o), 4);
        cfg_en_i = 1'b0;
        step();
        cfg_cpb_i = 16'd16; cfg_en_i = 1'b1;
        step(17);
        check("rearm cpb16 run", 32'(active_o), 1);

        // Overflow: 17 pushes into 16 entries.
        for (int i = 0; i < 17; i++) push_byte(8'(i));
        check("ovf level",   32'(level_o), 16);
        check("ovf flag",    32'(overflow_o), 1);
        check("ovf head",    32'(rd_data_o), 0);
        check("ovf wm off",  32'(wm_irq_o), 0);

        // Full FIFO with simultaneous push and pop.
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        check("clr level", 32'(level_o), 0);
        check("clr ovf",   32'(overflow_o), 0);
        for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
        check("full level", 32'(level_o), 16);
        core_dv_i = 1'b1; core_byte_i = 8'hA5; rd_ready_i = 1'b1;
        step();
        core_dv_i = 1'b0; rd_ready_i = 1'b0;
        check("pushpop level", 32'(level_o), 16);
        check("pushpop ovf",   32'(overflow_o), 0);
        check("pushpop head",  32'(rd_data_o), 8'h11);
        last = 8'h00;
        rd_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            last = rd_data_o;
            $display("[TB] pop 0x%02h", last);
            step();
        end
        rd_ready_i = 1'b0;
        check("drain tail", 32'(last), 8'hA5);
        check("drain level", 32'(level_o), 0);
        check("drain valid", 32'(rd_valid_o), 0);

        // Idle timeout with one byte held.
        push_byte(8'h3C);
        step(512);
        check("timeout early", 32'(timeout_o), 0);
        step();
        check("timeout set", 32'(timeout_o), 1);
        check("timeout head", 32'(rd_data_o), 8'h3C);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        $display("[TB] clr: level=%0d ovf=%0d to=%0d", level_o, overflow_o, timeout_o);
        check("clr2 level", 32'(level_o), 0);
        check("clr2 to",    32'(timeout_o), 0);
        check("clr2 ovf",   32'(overflow_o), 0);

        // Push into empty with pop requested: push only.
        core_dv_i = 1'b1; core_byte_i = 8'h77; rd_ready_i = 1'b1;
        step();
        core_dv_i = 1'b0; rd_ready_i = 1'b0;
        check("emptypush level", 32'(level_o), 1);
        check("emptypush head",  32'(rd_data_o), 8'h77);

        // Watermark at 4.
        cfg_wm_i = LW'(4);
        push_byte(8'h80);
        push_byte(8'h81);
        check("wm3 irq", 32'(wm_irq_o), 0);
        push_byte(8'h90);
        check("wm4 irq", 32'(wm_irq_o), 1);
        rd_ready_i = 1'b1;
        step();
        rd_ready_i = 1'b0;
        check("wm pop irq",  32'(wm_irq_o), 0);
        check("wm pop head", 32'(rd_data_o), 8'h80);

        // Disable while running: FIFO kept, core bytes ignored.
        cfg_en_i = 1'b0;
        step();
        check("off active", 32'(active_o), 0);
        check("off core_rst_no", 32'(core_rst_no), 0);
        check("off level kept", 32'(level_o), 3);
        push_byte(8'hEE);
        check("off push ignored", 32'(level_o), 3);

        // Asynchronous reset while arming.
        cfg_en_i = 1'b1;
        step(5);
        #1 rst_i = 1'b1;
        #1;
        check("async rst level", 32'(level_o), 0);
        check("async rst core_rst_no", 32'(core_rst_no), 0);
        check("async rst cpb", 32'(core_cpb_o), 4);
        step(2);
        rst_i = 1'b0; cfg_en_i = 1'b0;
        step(2);
        check("post rst active", 32'(active_o), 0);
        check("post rst level", 32'(level_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
